// File: rtl/scoreboard_hazard_unit.sv
// Scoreboard-based hazard unit: tracks outstanding long-latency writes per
// register, stalls ID on RAW/WAW/capacity hazards, holds if_id_flush for a
// configurable window after a redirect, and flags stalls that run too long.
//
// The only state machines here are counters; the control outputs are decoded
// combinationally each cycle in this priority order:
//   condition         | meaning
//   reset             | outputs idle, all state cleared at the edge
//   redirect          | wrong-path ID dropped, front end refilled
//   stall             | front end held, bubble into ID/EX
//   flush window      | IF/ID still invalidated after a redirect
//   idle              | normal advance
module scoreboard_hazard_unit #(
   parameter int REG_ADDR_W      = 5,
   parameter int MAX_OUTSTANDING = 4,
   parameter int FLUSH_CYCLES    = 1,
   parameter int STALL_TIMEOUT   = 1024,
   localparam int NUM_REGS       = 2 ** REG_ADDR_W,
   localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic                  id_writes_rd,
   input  logic                  id_long_lat,
   input  logic                  wb_long_valid,
   input  logic [REG_ADDR_W-1:0] wb_long_rd,
   input  logic                  redirect,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  if_id_flush,
   output logic                  id_ex_flush,
   output logic                  stall,
   output logic [CNT_W-1:0]      busy_count,
   output logic                  timeout_err
);

   localparam int FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam int ST_W = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;

   logic [NUM_REGS-1:0] pending;
   logic [NUM_REGS-1:0] clr;
   logic [NUM_REGS-1:0] set;
   logic [NUM_REGS-1:0] eff_pending;
   logic [CNT_W-1:0]    out_cnt;
   logic [FL_W-1:0]     flush_cnt;
   logic                err_q;

   logic raw_hz;
   logic waw_hz;
   logic full_hz;
   logic stall_int;
   logic issue;
   logic rd_nonzero;

   // Per-register completion and issue strobes; a completion only counts if
   // the register is actually outstanding.
   always_comb begin
      clr = '0;
      set = '0;
      if (wb_long_valid)
         clr[wb_long_rd] = pending[wb_long_rd];
      if (issue)
         set[id_rd] = 1'b1;
   end

   assign eff_pending = pending & ~clr;
   assign rd_nonzero  = (id_rd != '0);

   // Hazard detection; the capacity check ignores same-cycle completion.
   always_comb begin
      raw_hz  = id_valid && ((id_uses_rs1 && eff_pending[id_rs1]) ||
                             (id_uses_rs2 && eff_pending[id_rs2]));
      waw_hz  = id_valid && id_writes_rd && rd_nonzero && eff_pending[id_rd];
      full_hz = id_valid && id_long_lat && (out_cnt == CNT_W'(MAX_OUTSTANDING));
      stall_int = (raw_hz || waw_hz || full_hz) && !redirect;
      issue   = id_valid && id_long_lat && id_writes_rd && rd_nonzero &&
                !stall_int && !redirect;
   end

   // Pipeline control decode; reset forces the idle pattern.
   always_comb begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      stall       = 1'b0;
      busy_count  = '0;
      timeout_err = 1'b0;
      if (rst_n) begin
         busy_count  = out_cnt;
         timeout_err = err_q;
         if (redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end else if (stall_int) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            stall       = 1'b1;
         end else if (flush_cnt != '0) begin
            if_id_flush = 1'b1;
         end
      end
   end

   // Scoreboard and outstanding counter; a set beats a same-cycle clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending <= '0;
         out_cnt <= '0;
      end else begin
         pending <= ((pending & ~clr) | set) & ~NUM_REGS'(1);
         out_cnt <= out_cnt + CNT_W'(issue) - CNT_W'(|clr);
      end
   end

   // Flush window: loaded by each redirect, then counts down to zero.
   always_ff @(posedge clk) begin
      if (!rst_n)
         flush_cnt <= '0;
      else if (redirect)
         flush_cnt <= FL_W'(FLUSH_CYCLES - 1);
      else if (flush_cnt != '0)
         flush_cnt <= flush_cnt - 1'b1;
   end

   generate
      if (STALL_TIMEOUT > 0) begin : g_wdog
         logic [ST_W-1:0] stall_cnt;

         // Watchdog: count consecutive stall cycles, latch a sticky error.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               stall_cnt <= '0;
               err_q     <= 1'b0;
            end else begin
               if (!stall_int)
                  stall_cnt <= '0;
               else if (stall_cnt != '1)
                  stall_cnt <= stall_cnt + 1'b1;
               if (stall_int && (stall_cnt == ST_W'(STALL_TIMEOUT - 1)))
                  err_q <= 1'b1;
            end
         end
      end else begin : g_no_wdog
         // Watchdog disabled: error never raised.
         always_ff @(posedge clk) begin
            err_q <= 1'b0;
         end
      end
   endgenerate

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Directed bench for scoreboard_hazard_unit with MAX_OUTSTANDING=4,
// FLUSH_CYCLES=3 and STALL_TIMEOUT=8.
module tb_scoreboard_hazard_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic [4:0] id_rd;
   logic       id_uses_rs1;
   logic       id_uses_rs2;
   logic       id_writes_rd;
   logic       id_long_lat;
   logic       wb_long_valid;
   logic [4:0] wb_long_rd;
   logic       redirect;
   logic       pc_write;
   logic       if_id_write;
   logic       if_id_flush;
   logic       id_ex_flush;
   logic       stall;
   logic [2:0] busy_count;
   logic       timeout_err;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   scoreboard_hazard_unit #(
      .REG_ADDR_W(5), .MAX_OUTSTANDING(4), .FLUSH_CYCLES(3), .STALL_TIMEOUT(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1),
      .id_rs2(id_rs2), .id_rd(id_rd), .id_uses_rs1(id_uses_rs1),
      .id_uses_rs2(id_uses_rs2), .id_writes_rd(id_writes_rd),
      .id_long_lat(id_long_lat), .wb_long_valid(wb_long_valid),
      .wb_long_rd(wb_long_rd), .redirect(redirect), .pc_write(pc_write),
      .if_id_write(if_id_write), .if_id_flush(if_id_flush),
      .id_ex_flush(id_ex_flush), .stall(stall), .busy_count(busy_count),
      .timeout_err(timeout_err)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clr_in();
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
      id_uses_rs1 = 0; id_uses_rs2 = 0; id_writes_rd = 0; id_long_lat = 0;
      wb_long_valid = 0; wb_long_rd = 0; redirect = 0;
   endtask

   // advance one clock; inputs change 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // settle combinational outputs before sampling
   task automatic settle();
      #2;
   endtask

   task automatic long_op(input int rd);
      clr_in();
      id_valid = 1; id_long_lat = 1; id_writes_rd = 1; id_rd = 5'(rd);
   endtask

   task automatic read_rs1(input int rs);
      clr_in();
      id_valid = 1; id_uses_rs1 = 1; id_rs1 = 5'(rs);
   endtask

   task automatic complete(input int rd);
      clr_in();
      wb_long_valid = 1; wb_long_rd = 5'(rd);
   endtask

   initial begin
      clr_in();
      rst_n = 0;
      redirect = 1;
      step(); step();
      settle();
      chk("rst_pc_write", pc_write, 1);
      chk("rst_if_id_write", if_id_write, 1);
      chk("rst_if_id_flush", if_id_flush, 0);
      chk("rst_id_ex_flush", id_ex_flush, 0);
      chk("rst_stall", stall, 0);
      chk("rst_busy", busy_count, 0);
      chk("rst_timeout", timeout_err, 0);
      rst_n = 1;
      clr_in();
      step();

      // RAW on a long load to x5
      long_op(5); settle();
      chk("t1_issue_nostall", stall, 0);
      step();
      read_rs1(5); settle();
      chk("t1_busy1", busy_count, 1);
      chk("t1_raw_stall", stall, 1);
      chk("t1_raw_idex", id_ex_flush, 1);
      chk("t1_raw_pcw", pc_write, 0);
      chk("t1_raw_ifidw", if_id_write, 0);
      step(); settle();
      chk("t1_raw_stall2", stall, 1);
      step();
      wb_long_valid = 1; wb_long_rd = 5; settle();
      chk("t1_wb_release", stall, 0);
      chk("t1_wb_pcw", pc_write, 1);
      chk("t1_wb_busy", busy_count, 1);
      step(); clr_in(); settle();
      chk("t1_busy0", busy_count, 0);

      // capacity limit
      for (int r = 1; r <= 4; r++) begin
         long_op(r); step();
      end
      long_op(6);
      wb_long_valid = 1; wb_long_rd = 2; settle();
      chk("t2_full_busy", busy_count, 4);
      chk("t2_full_stall", stall, 1);
      step();
      wb_long_valid = 0; settle();
      chk("t2_after_clr_busy", busy_count, 3);
      chk("t2_issue_nostall", stall, 0);
      step(); clr_in(); settle();
      chk("t2_busy_refill", busy_count, 4);
      complete(1); step();
      complete(3); step();
      complete(4); step();
      complete(6); step();
      clr_in(); settle();
      chk("t2_drained", busy_count, 0);

      // WAW on x7 overridden by redirect
      long_op(7); step();
      long_op(7); redirect = 1; settle();
      chk("t3_redir_stall", stall, 0);
      chk("t3_redir_ifid", if_id_flush, 1);
      chk("t3_redir_idex", id_ex_flush, 1);
      chk("t3_redir_pcw", pc_write, 1);
      step(); clr_in(); settle();
      chk("t3_no_issue_busy", busy_count, 1);
      step(); step();
      clr_in(); id_valid = 1; id_uses_rs2 = 1; id_rs2 = 7; settle();
      chk("t3_x7_pending", stall, 1);
      chk("t3_window_over", if_id_flush, 0);
      wb_long_valid = 1; wb_long_rd = 7; settle();
      chk("t3_x7_release", stall, 0);
      step(); clr_in(); settle();
      chk("t3_busy0", busy_count, 0);

      // flush window, single then back-to-back redirects
      redirect = 1; settle();
      chk("t4_n", if_id_flush, 1);
      step(); redirect = 0; settle();
      chk("t4_n1", if_id_flush, 1);
      chk("t4_n1_idex", id_ex_flush, 0);
      chk("t4_n1_pcw", pc_write, 1);
      step(); settle();
      chk("t4_n2", if_id_flush, 1);
      step(); settle();
      chk("t4_n3", if_id_flush, 0);
      step();
      redirect = 1; step();
      redirect = 1; settle();
      chk("t4b_n1", if_id_flush, 1);
      step(); redirect = 0; settle();
      chk("t4b_n2", if_id_flush, 1);
      step(); settle();
      chk("t4b_n3", if_id_flush, 1);
      step(); settle();
      chk("t4b_n4", if_id_flush, 0);

      // watchdog on x3 that never completes
      long_op(3); step();
      read_rs1(3);
      for (int i = 1; i <= 7; i++) begin
         settle();
         chk($sformatf("t5_stall_c%0d", i), stall, 1);
         chk($sformatf("t5_no_err_c%0d", i), timeout_err, 0);
         step();
      end
      step(); settle();
      chk("t5_err_set", timeout_err, 1);
      wb_long_valid = 1; wb_long_rd = 3; settle();
      chk("t5_release", stall, 0);
      step(); clr_in(); settle();
      chk("t5_err_sticky", timeout_err, 1);
      chk("t5_busy0", busy_count, 0);
      long_op(12); step(); clr_in(); settle();
      chk("t5_busy_pre_rst", busy_count, 1);
      rst_n = 0; read_rs1(12); settle();
      chk("t5_rst_stall", stall, 0);
      chk("t5_rst_pcw", pc_write, 1);
      chk("t5_rst_busy", busy_count, 0);
      chk("t5_rst_err", timeout_err, 0);
      step(); rst_n = 1; settle();
      chk("t5_x12_dropped", stall, 0);
      chk("t5_post_busy", busy_count, 0);
      chk("t5_post_err", timeout_err, 0);

      // stray completion and x0 destination
      long_op(8); step();
      long_op(0); wb_long_valid = 1; wb_long_rd = 9; settle();
      chk("t6_x0_nostall", stall, 0);
      chk("t6_busy_before", busy_count, 1);
      step(); clr_in(); settle();
      chk("t6_busy_unchanged", busy_count, 1);
      read_rs1(0); id_uses_rs2 = 1; id_rs2 = 0; settle();
      chk("t6_read_x0", stall, 0);
      step();
      read_rs1(8); settle();
      chk("t6_x8_pending", stall, 1);
      complete(8); step(); clr_in(); settle();
      chk("t6_busy0", busy_count, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/scoreboard_hazard_unit.md
Name: scoreboard_hazard_unit

Overview:
Parametrised successor to the pipeline hazard unit. It adds a per-register scoreboard for variable-latency writers (loads on a stalling memory, multi-cycle mul/div), so stalls last exactly as long as the producer is outstanding rather than a fixed one cycle. It also adds a multi-cycle front-end flush window for deeper fetch pipelines and a stall watchdog. It sits beside the ID stage, drives PC/IF-ID/ID-EX control, and receives completions from the long-latency writeback port.

Parameters:
REG_ADDR_W, 5, register index width; NUM_REGS = 2**REG_ADDR_W.
MAX_OUTSTANDING, 4, maximum in-flight long-latency writes (1..NUM_REGS-1); CNT_W = clog2(MAX_OUTSTANDING+1).
FLUSH_CYCLES, 1, cycles if_id_flush is held after a redirect (>=1).
STALL_TIMEOUT, 1024, consecutive stall cycles before timeout_err is raised; 0 disables the watchdog; counter width clog2(STALL_TIMEOUT+1).

Ports:
clk  in  1  clock.
rst_n  in  1  synchronous active-low reset.
id_valid  in  1  ID holds a valid instruction.
id_rs1  in  REG_ADDR_W  source 1 index.
id_rs2  in  REG_ADDR_W  source 2 index.
id_rd  in  REG_ADDR_W  destination index.
id_uses_rs1  in  1  instruction reads rs1.
id_uses_rs2  in  1  instruction reads rs2.
id_writes_rd  in  1  instruction writes rd.
id_long_lat  in  1  instruction is issued to a long-latency unit.
wb_long_valid  in  1  long-latency result written back this cycle.
wb_long_rd  in  REG_ADDR_W  destination of that result.
redirect  in  1  taken branch or jump resolved this cycle.
pc_write  out  1  PC update enable.
if_id_write  out  1  IF/ID update enable.
if_id_flush  out  1  invalidate IF/ID.
id_ex_flush  out  1  insert bubble into ID/EX.
stall  out  1  front end held.
busy_count  out  CNT_W  outstanding long-latency writes.
timeout_err  out  1  sticky watchdog error.

Behaviour:
- State: pending[NUM_REGS], out_cnt, flush_cnt, stall_cnt, timeout_err. pending[0] is never set.
- Same-cycle completion: clr[r] = wb_long_valid && wb_long_rd==r && pending[r]. eff_pending[r] = pending[r] && !clr[r]. WB forwarding covers the completing register.
- RAW hazard: id_valid && ((id_uses_rs1 && eff_pending[id_rs1]) || (id_uses_rs2 && eff_pending[id_rs2])).
- WAW hazard: id_valid && id_writes_rd && id_rd!=0 && eff_pending[id_rd].
- FULL hazard: id_valid && id_long_lat && out_cnt==MAX_OUTSTANDING. Same-cycle completion is ignored here (conservative).
- stall = (RAW|WAW|FULL) && !redirect. Redirect has priority because the ID instruction is wrong-path.
- Outputs are combinational from state and inputs:
  - stall: pc_write=0, if_id_write=0, id_ex_flush=1, if_id_flush=0.
  - redirect: pc_write=1, if_id_write=1, id_ex_flush=1, if_id_flush=1.
  - flush_cnt!=0 with no redirect: if_id_flush=1, others idle.
  - otherwise idle: pc_write=1, if_id_write=1, flushes 0, stall 0.
- Issue: issue = id_valid && id_long_lat && id_writes_rd && id_rd!=0 && !stall && !redirect. On issue, pending[id_rd] is set next cycle. If the same register is also completing, set wins.
- Count update: out_cnt next = out_cnt + issue - (|clr). A completion for a non-pending register is ignored entirely (no count change).
- Redirect: flush_cnt loads FLUSH_CYCLES-1. While flush_cnt!=0 it decrements each cycle. A new redirect reloads it. Pending entries are never cancelled by redirect, since their producers are older than the branch.
- Watchdog: stall_cnt increments on stall (saturating) and clears when stall=0. When stall_cnt reaches STALL_TIMEOUT-1 with stall high, timeout_err is set and stays set until reset.
- Reset (rst_n low at a clk edge): all state cleared. While rst_n is low, outputs are forced to idle: pc_write=1, if_id_write=1, flushes 0, stall 0, busy_count 0, timeout_err 0. Reset mid-stall or mid-flush drops all pending entries.

Test Plan:
- Issue long load to x5; next cycle ID reads x5 (uses_rs1) -> stall=1 and id_ex_flush=1 each cycle until wb_long_valid/wb_long_rd=5. That cycle stall=0; busy_count goes 1->0.
- Issue 4 long ops to x1..x4 (MAX_OUTSTANDING=4), then a long op to x6 -> busy_count=4 and stall=1. Completion of x2 that cycle -> still stalled; next cycle issues, busy_count=4.
- x7 pending, ID writes x7 (WAW) with redirect=1 same cycle -> stall=0, if_id_flush=1, id_ex_flush=1, no issue, x7 still pending.
- FLUSH_CYCLES=3, redirect pulse at cycle N -> if_id_flush high for N..N+2. Second redirect at N+1 -> high through N+3.
- STALL_TIMEOUT=8, x3 pending and never completed, ID reads x3 -> timeout_err=1 on the 8th stall cycle and stays 1 after completion. rst_n=0 for one cycle -> all outputs idle, busy_count=0.
- wb_long_valid for x9 not pending, and ID reads x0 while x0 is an issued long-op rd -> no count change, no stall, busy_count unchanged.
